// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch-unit parameter defaults and the next-PC source encoding.
package cpu_defs;

  localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF    = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BYTES_DEF = 32'h0000_4000;
  localparam logic [31:0] INC_DEF        = 32'd4;

  typedef enum logic [2:0] {
    RST,
    EXC,
    ERET,
    HOLD,
    REDIR,
    PEND,
    SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the hazard/D-stage/CP0 side and the PC unit.
interface pc_unit_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              stall;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              adel;
  logic              pend_valid;

  modport master (
    output stall, redir_valid, redir_target, exc_req, eret_req, epc,
    input  pc, pc_plus, adel, pend_valid
  );

  modport slave (
    input  stall, redir_valid, redir_target, exc_req, eret_req, epc,
    output pc, pc_plus, adel, pend_valid
  );

endinterface

// File: rtl/pc_addr_check.sv
// Combinational AdEL checker: word alignment plus legal-window bounds.
// Shared with the M-stage load/store address check.
module pc_addr_check
  import cpu_defs::*;
#(
  parameter int unsigned        ADDR_W = 32,
  parameter logic [ADDR_W-1:0]  BASE   = ADDR_W'(IMEM_BASE_DEF),
  parameter logic [ADDR_W-1:0]  BYTES  = ADDR_W'(IMEM_BYTES_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              adel
);

  // One extra bit so BASE + BYTES cannot wrap at the top of the address space.
  logic [ADDR_W:0] lo;
  logic [ADDR_W:0] hi;
  logic [ADDR_W:0] addr_ext;

  assign lo       = {1'b0, BASE};
  assign hi       = lo + {1'b0, BYTES};
  assign addr_ext = {1'b0, addr};

  assign adel = (addr[1:0] != 2'b00) || (addr_ext < lo) || (addr_ext >= hi);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC selection and a one-entry
// pending-redirect buffer for redirects that arrive while stalled.
//   src   | meaning
//   RST   | load RESET_VEC, drop pending redirect
//   EXC   | exception entry, ignores stall
//   ERET  | return to epc, ignores stall
//   HOLD  | stalled; capture/overwrite redirect into buffer
//   REDIR | live redirect, beats buffered one
//   PEND  | replay buffered redirect
//   SEQ   | pc + INC
module pc_unit
  import cpu_defs::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(EXC_VEC_DEF),
  parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(IMEM_BASE_DEF),
  parameter logic [ADDR_W-1:0] IMEM_BYTES = ADDR_W'(IMEM_BYTES_DEF),
  parameter logic [ADDR_W-1:0] INC        = ADDR_W'(INC_DEF)
) (
  input  logic        clk,
  input  logic        reset,
  pc_unit_if.slave    bus
);

  pc_src_e           src;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              pend_valid_q;
  logic              pend_valid_nxt;
  logic [ADDR_W-1:0] pend_target_q;
  logic [ADDR_W-1:0] pend_target_nxt;
  logic              adel_w;

  assign pc_inc = pc_q + INC;

  always_comb begin
    src = SEQ;
    if (reset)                  src = RST;
    else if (bus.exc_req)       src = EXC;
    else if (bus.eret_req)      src = ERET;
    else if (bus.stall)         src = HOLD;
    else if (bus.redir_valid)   src = REDIR;
    else if (pend_valid_q)      src = PEND;

    pc_nxt          = pc_inc;
    pend_valid_nxt  = pend_valid_q;
    pend_target_nxt = pend_target_q;

    case (src)
      RST: begin
        pc_nxt          = RESET_VEC;
        pend_valid_nxt  = 1'b0;
        pend_target_nxt = '0;
      end
      EXC: begin
        pc_nxt         = EXC_VEC;
        pend_valid_nxt = 1'b0;
      end
      ERET: begin
        pc_nxt         = bus.epc;
        pend_valid_nxt = 1'b0;
      end
      HOLD: begin
        pc_nxt = pc_q;
        if (bus.redir_valid) begin
          pend_valid_nxt  = 1'b1;
          pend_target_nxt = bus.redir_target;
        end
      end
      REDIR: begin
        pc_nxt         = bus.redir_target;
        pend_valid_nxt = 1'b0;
      end
      PEND: begin
        pc_nxt         = pend_target_q;
        pend_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    pc_q          <= pc_nxt;
    pend_valid_q  <= pend_valid_nxt;
    pend_target_q <= pend_target_nxt;
  end

  pc_addr_check #(
    .ADDR_W (ADDR_W),
    .BASE   (IMEM_BASE),
    .BYTES  (IMEM_BYTES)
  ) u_addr_check (
    .addr (pc_q),
    .adel (adel_w)
  );

  assign bus.pc         = pc_q;
  assign bus.pc_plus    = pc_inc;
  assign bus.adel       = adel_w;
  assign bus.pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: default 32-bit instance plus a 16-bit wrap instance.
module tb_pc_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset16 = 1'b1;

  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(32)) bus();
  pc_unit_if #(.ADDR_W(16)) bus16();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_unit #(
    .ADDR_W    (16),
    .RESET_VEC (16'hFFFC)
  ) dut16 (
    .clk   (clk),
    .reset (reset16),
    .bus   (bus16)
  );

  typedef struct {
    bit          d16;
    logic [31:0] pc;
    logic [31:0] pcp;
    logic        pv;
    logic        adel;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares the post-edge outputs of whichever DUT the entry names.
  always begin
    exp_t e;
    logic [31:0] a_pc, a_pcp;
    logic        a_pv, a_adel;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.d16) begin
        a_pc = {16'h0, bus16.pc}; a_pcp = {16'h0, bus16.pc_plus};
        a_pv = bus16.pend_valid;  a_adel = bus16.adel;
      end else begin
        a_pc = bus.pc; a_pcp = bus.pc_plus;
        a_pv = bus.pend_valid; a_adel = bus.adel;
      end
      checks++;
      if (a_pc !== e.pc || a_pcp !== e.pcp || a_pv !== e.pv || a_adel !== e.adel) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus=%h pend=%b adel=%b, expected pc=%h pc_plus=%h pend=%b adel=%b",
                 e.nm, a_pc, a_pcp, a_pv, a_adel, e.pc, e.pcp, e.pv, e.adel);
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rt,
                      input logic ex, input logic er, input logic [31:0] ep,
                      input logic [31:0] e_pc, input logic [31:0] e_pcp, input logic e_pv,
                      input logic e_adel, input string nm);
    exp_t e;
    @(negedge clk);
    reset            = rst;
    bus.stall        = st;
    bus.redir_valid  = rv;
    bus.redir_target = rt;
    bus.exc_req      = ex;
    bus.eret_req     = er;
    bus.epc          = ep;
    e.d16 = 1'b0; e.pc = e_pc; e.pcp = e_pcp; e.pv = e_pv; e.adel = e_adel; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step16(input logic rst, input logic [31:0] e_pc, input logic [31:0] e_pcp,
                        input logic e_adel, input string nm);
    exp_t e;
    @(negedge clk);
    reset16 = rst;
    e.d16 = 1'b1; e.pc = e_pc; e.pcp = e_pcp; e.pv = 1'b0; e.adel = e_adel; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    int wait_cyc;
    bus.stall = 1'b0; bus.redir_valid = 1'b0; bus.redir_target = '0;
    bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.epc = '0;
    bus16.stall = 1'b0; bus16.redir_valid = 1'b0; bus16.redir_target = '0;
    bus16.exc_req = 1'b0; bus16.eret_req = 1'b0; bus16.epc = '0;

    //   rst st rv target        ex er epc           pc            pc_plus       pv adel
    step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 32'h0000_3004, 0, 0, "reset");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 32'h0000_3008, 0, 0, "seq1");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 32'h0000_300C, 0, 0, "seq2");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 32'h0000_3010, 0, 0, "seq3");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 32'h0000_3014, 0, 0, "seq4");
    step(0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3010, 32'h0000_3014, 1, 0, "stall_redir1");
    step(0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3010, 32'h0000_3014, 1, 0, "stall_redir2");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3400, 32'h0000_3404, 0, 0, "pend_replay");
    step(0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3400, 32'h0000_3404, 1, 0, "pend_again");
    step(0, 0, 1, 32'h3800,     0, 0, 32'h0,        32'h0000_3800, 32'h0000_3804, 0, 0, "live_beats_pend");
    step(0, 1, 1, 32'h3500,     0, 0, 32'h0,        32'h0000_3800, 32'h0000_3804, 1, 0, "pend_before_exc");
    step(0, 1, 0, 32'h0,        1, 1, 32'h3100,     32'h0000_4180, 32'h0000_4184, 0, 0, "exc_over_eret");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4184, 32'h0000_4188, 0, 0, "exc_resume");
    step(0, 0, 0, 32'h0,        0, 1, 32'h3002,     32'h0000_3002, 32'h0000_3006, 0, 1, "eret_misaligned");
    step(0, 0, 1, 32'h7000,     0, 0, 32'h0,        32'h0000_7000, 32'h0000_7004, 0, 1, "window_end");
    step(0, 0, 1, 32'h6FFC,     0, 0, 32'h0,        32'h0000_6FFC, 32'h0000_7000, 0, 0, "window_last");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 32'h0000_7004, 0, 1, "seq_out_window");
    step(0, 0, 1, 32'h2FFC,     0, 0, 32'h0,        32'h0000_2FFC, 32'h0000_3000, 0, 1, "below_base");
    step(0, 1, 1, 32'h3600,     0, 0, 32'h0,        32'h0000_2FFC, 32'h0000_3000, 1, 1, "pend_before_reset");
    step(1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 32'h0000_3004, 0, 0, "reset_in_stall");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 32'h0000_3008, 0, 0, "pend_lost");
    step(0, 1, 1, 32'h3200,     0, 0, 32'h0,        32'h0000_3004, 32'h0000_3008, 1, 0, "pend_first");
    step(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 32'h0000_3008, 1, 0, "stall_hold");
    step(0, 1, 1, 32'h3300,     0, 0, 32'h0,        32'h0000_3004, 32'h0000_3008, 1, 0, "pend_overwrite");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3300, 32'h0000_3304, 0, 0, "pend_newest");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3304, 32'h0000_3308, 0, 0, "seq_after_pend");

    // 16-bit instance: wrap from 0xFFFC; both addresses fall outside the default window.
    step16(1, 32'h0000_FFFC, 32'h0000_0000, 1, "w16_reset");
    step16(0, 32'h0000_0000, 32'h0000_0004, 1, "w16_wrap");
    step16(0, 32'h0000_0004, 32'h0000_0008, 1, "w16_seq");

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
